// File: rtl/config_stream_loader.sv
// Configuration bitstream loader: checks a header, then turns each (address, data)
// word pair from the host into one single-cycle write on the fabric config bus.
module config_stream_loader #(
    parameter logic [15:0] MAGIC       = 16'hC0F1,
    parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
    parameter logic [15:0] MIN_SECTION = 16'd4,
    parameter logic [15:0] MAX_SECTION = 16'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] writes_issued
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [15:0] remaining;
    logic        xfer;
    logic [15:0] section;

    assign xfer    = in_valid && in_ready;
    assign section = in_data[31:16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_reg      <= '0;
            data_reg      <= '0;
            remaining     <= '0;
            writes_issued <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) writes_issued <= '0;
                end
                HDR: begin
                    if (xfer) remaining <= in_data[15:0];
                end
                ADDR: begin
                    if (xfer) addr_reg <= in_data;
                end
                DATA: begin
                    if (xfer) data_reg <= in_data;
                end
                WRITE: begin
                    writes_issued <= writes_issued + 16'd1;
                    remaining     <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus and handshake outputs are decoded from state so in_ready never depends on in_valid.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        config_addr = IDLE_ADDR;
        config_data = 32'h0;
        case (state)
            IDLE: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (in_data[31:16] != MAGIC) state_next = ERROR;
                    else if (in_data[15:0] == 16'd0) state_next = DONE;
                    else state_next = ADDR;
                end
            end
            ADDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (section < MIN_SECTION || section > MAX_SECTION) state_next = ERROR;
                    else state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                config_addr = addr_reg;
                config_data = data_reg;
                state_next  = (remaining == 16'd1) ? DONE : ADDR;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = HDR;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = HDR;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: header checks, write sequencing,
// host stalls, mid-load reset and start-while-busy.
module tb_config_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] writes_issued;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_rises = 0;
    logic done_prev = 1'b0;
    logic random_stall = 1'b0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    config_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .writes_issued(writes_issued)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle the bus carries a write, sampled mid-cycle.
    always @(negedge clk) begin
        if (config_addr !== 32'h0 || config_data !== 32'h0) begin
            wr_addr.push_back(config_addr);
            wr_data.push_back(config_data);
            wr_cyc.push_back(cyc);
        end
        if (done && !done_prev) done_rises <= done_rises + 1;
        done_prev <= done;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until it transfers, optionally with random valid stalls.
    task automatic applyStimulus(input logic [31:0] word);
        logic xf;
        bit   ok;
        ok      = 1'b0;
        in_data = word;
        for (int i = 0; i < 60; i++) begin
            in_valid = random_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            xf = in_valid && in_ready;
            tick();
            if (xf) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("send_timeout", word, 32'hFFFF_FFFF);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitEnd(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done || error) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) checkOutput(tag, 32'(busy), 32'h0);
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_writes", 32'(writes_issued), 32'd0);
        checkOutput("rst_addr", config_addr, 32'h0);
        checkOutput("rst_data", config_data, 32'h0);

        // Two-pair load with valid held high, checked cycle by cycle.
        clearLog();
        pulseStart();
        checkOutput("t1_hdr_ready", 32'(in_ready), 32'd1);
        checkOutput("t1_hdr_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'hC0F1_0002;
        tick();
        in_data = 32'h0007_0003;
        tick();
        in_data = 32'h0000_0005;
        tick();
        checkOutput("t1_w1_addr", config_addr, 32'h0007_0003);
        checkOutput("t1_w1_data", config_data, 32'h0000_0005);
        checkOutput("t1_w1_ready", 32'(in_ready), 32'd0);
        in_data = 32'h0004_0003;
        tick();
        checkOutput("t1_gap_addr", config_addr, 32'h0);
        checkOutput("t1_gap_writes", 32'(writes_issued), 32'd1);
        tick();
        in_data = 32'h0000_0002;
        tick();
        checkOutput("t1_w2_addr", config_addr, 32'h0004_0003);
        checkOutput("t1_w2_data", config_data, 32'h0000_0002);
        in_valid = 1'b0;
        tick();
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_writes", 32'(writes_issued), 32'd2);
        tick();
        checkOutput("t1_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_cyc.size() == 2) checkOutput("t1_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);

        // Bad magic, then an empty load.
        clearLog();
        pulseStart();
        checkOutput("t2_done_cleared", 32'(done), 32'd0);
        applyStimulus(32'hBEEF_0001);
        checkOutput("t2_error", 32'(error), 32'd1);
        checkOutput("t2_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_done", 32'(done), 32'd0);
        pulseStart();
        checkOutput("t2_error_cleared", 32'(error), 32'd0);
        applyStimulus(32'hC0F1_0000);
        checkOutput("t2_empty_done", 32'(done), 32'd1);
        checkOutput("t2_empty_writes", 32'(writes_issued), 32'd0);
        checkOutput("t2_nwrites", 32'(wr_addr.size()), 32'd0);

        // Illegal section aborts without consuming the data word.
        clearLog();
        pulseStart();
        applyStimulus(32'hC0F1_0001);
        applyStimulus(32'h0009_0001);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000_00AA;
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("t3_still_error", 32'(error), 32'd1);
        checkOutput("t3_writes", 32'(writes_issued), 32'd0);
        checkOutput("t3_nwrites", 32'(wr_addr.size()), 32'd0);

        // Three pairs with random host stalls.
        clearLog();
        random_stall = 1'b1;
        pulseStart();
        applyStimulus(32'hC0F1_0003);
        applyStimulus(32'h0005_0010);
        applyStimulus(32'hDEAD_BEEF);
        applyStimulus(32'h0006_0020);
        applyStimulus(32'h1234_5678);
        applyStimulus(32'h0004_FFFF);
        applyStimulus(32'h0000_0001);
        random_stall = 1'b0;
        waitEnd("t4_timeout");
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_writes", 32'(writes_issued), 32'd3);
        checkOutput("t4_nwrites", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            checkOutput("t4_a0", wr_addr[0], 32'h0005_0010);
            checkOutput("t4_d0", wr_data[0], 32'hDEAD_BEEF);
            checkOutput("t4_a1", wr_addr[1], 32'h0006_0020);
            checkOutput("t4_d1", wr_data[1], 32'h1234_5678);
            checkOutput("t4_a2", wr_addr[2], 32'h0004_FFFF);
            checkOutput("t4_d2", wr_data[2], 32'h0000_0001);
        end

        // Reset (with a simultaneous start) while in DATA of pair 2 of 4.
        clearLog();
        pulseStart();
        applyStimulus(32'hC0F1_0004);
        applyStimulus(32'h0004_0001);
        applyStimulus(32'h1111_1111);
        applyStimulus(32'h0005_0002);
        checkOutput("t5_busy_pre", 32'(busy), 32'd1);
        checkOutput("t5_writes_pre", 32'(writes_issued), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_addr", config_addr, 32'h0);
        checkOutput("t5_writes", 32'(writes_issued), 32'd0);
        checkOutput("t5_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t5_idle_hold", 32'(busy), 32'd0);
        checkOutput("t5_nwrites", 32'(wr_addr.size()), 32'd1);

        // start pulses while busy are ignored.
        clearLog();
        done_rises = 0;
        pulseStart();
        applyStimulus(32'hC0F1_0002);
        start = 1'b1;
        applyStimulus(32'h0007_0100);
        start = 1'b0;
        applyStimulus(32'h0000_0033);
        pulseStart();
        checkOutput("t6_writes_mid", 32'(writes_issued), 32'd1);
        checkOutput("t6_busy_mid", 32'(busy), 32'd1);
        applyStimulus(32'h0006_0200);
        applyStimulus(32'h0000_0044);
        waitEnd("t6_timeout");
        tick();
        tick();
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_writes", 32'(writes_issued), 32'd2);
        checkOutput("t6_done_once", 32'(done_rises), 32'd1);
        checkOutput("t6_nwrites", 32'(wr_addr.size()), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Streams a configuration bitstream into the fabric's shared config bus (config_addr/config_data) that every PE tile decodes against its tile_id.
- Sits directly upstream of the tile array. Accepts 32-bit words from a host over a valid/ready handshake, checks a header, and issues one single-cycle config write per (address, data) word pair.
- Reports busy, done, error and the count of writes issued.

Parameters:
- MAGIC, 16'hC0F1, required value of header bits [31:16].
- IDLE_ADDR, 32'h0000_0000, value driven on config_addr when no write is in progress; must match no tile section.
- MIN_SECTION, 16'd4, lowest legal config_addr[31:16] section code.
- MAX_SECTION, 16'd7, highest legal config_addr[31:16] section code.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR.
- in_valid  input  1  host word valid.
- in_data  input  32  host word.
- in_ready  output  1  loader can accept a word this cycle.
- config_addr  output  32  fabric config address: [31:16] section, [15:0] tile id.
- config_data  output  32  fabric config data.
- busy  output  1  high in HDR, ADDR, DATA and WRITE.
- done  output  1  load completed successfully; held.
- error  output  1  load aborted; held.
- writes_issued  output  16  number of config writes issued in the current or last load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, config_addr=IDLE_ADDR, config_data=0, in_ready=0, busy=0, done=0, error=0, writes_issued=0, remaining=0.
- A word transfers only on a cycle where in_valid && in_ready. in_ready is a registered or state-decoded output and does not depend on in_valid.
- IDLE: in_ready=0. On start, go to HDR and clear done, error and writes_issued.
- HDR: in_ready=1. On transfer:
  - in_data[31:16]!=MAGIC: go to ERROR.
  - in_data[15:0]==0: go to DONE with no writes.
  - Otherwise: remaining=in_data[15:0], go to ADDR.
- ADDR: in_ready=1. On transfer, latch addr_reg=in_data.
  - Section in_data[31:16] outside [MIN_SECTION, MAX_SECTION]: go to ERROR with no write for this pair; the data word is not consumed.
  - Otherwise: go to DATA.
- DATA: in_ready=1. On transfer, latch data_reg=in_data and go to WRITE.
- WRITE: in_ready=0.
  - config_addr=addr_reg and config_data=data_reg for exactly this one cycle.
  - writes_issued increments and remaining decrements.
  - If remaining was 1, go to DONE; else go to ADDR.
- Outside WRITE, config_addr=IDLE_ADDR and config_data=0 on every cycle.
- Latency: the data word transfers at cycle t; the write is visible on the config bus at cycle t+1.
- Throughput: at most one write per 3 cycles. Host stalls (in_valid=0) simply hold the current state.
- DONE: done=1, in_ready=0, held until start (go to HDR) or reset.
- ERROR: error=1, in_ready=0, held until start (go to HDR) or reset.
- start while busy=1 is ignored.
- start in the same cycle as reset: reset wins.
- Reset mid-load: immediate return to IDLE with the bus idle on the next cycle. Writes already issued are not rolled back.
- remaining is 16 bits. A header count of 16'hFFFF is legal and produces 65535 writes. writes_issued cannot overflow within one load.
- done and error are never high together.

Test Plan:
- Header 32'hC0F1_0002, pairs (32'h0007_0003, 32'h0000_0005) and (32'h0004_0003, 32'h0000_0002), in_valid held high -> exactly two single-cycle bus writes with those values, 3 cycles apart. done=1 and writes_issued=2 afterward. config_addr=0 on all other cycles.
- Header 32'hBEEF_0001 -> error=1 on the cycle after the header transfer, no bus write, in_ready=0. A following start plus a valid header 32'hC0F1_0000 -> done=1, writes_issued=0.
- Header count 1, address 32'h0009_0001 (section 9 > MAX_SECTION) -> error=1, no write, data word not accepted (in_ready=0).
- Valid 3-pair load with in_valid toggled randomly (~50%) -> identical write sequence, each write delayed accordingly, config bus idle during stalls.
- Reset asserted in DATA state of pair 2 of 4 -> next cycle: state IDLE, busy=0, config_addr=0, writes_issued=0. Only pair 1 was written.
- start pulsed while busy -> no effect. Load completes normally and done=1 exactly once.
